conv_result_writer: RTL
=======================

// Module: conv_result_writer
// PURPOSE
//  Write end of the conv sliding-window datapath. Accepts one conv result per window position,
//  in row-major (i,j) order, over a valid/ready stream. Writes each result to the output
//  feature-map RAM at base + i*OUT_C + j. Signals frame completion and raises a sticky error
//  when the incoming position tags disagree with its own position counters.
// PARAMETERS
//  N_C      5   image columns
//  N_R      3   image rows
//  COL_FIL  2   filter columns
//  ROW_FIL  2   filter rows
//  DATA_W   16  result width, two's complement
//  ADDR_W   8   output RAM address width
//  derived: OUT_C = N_C-COL_FIL+1 (4), OUT_R = N_R-ROW_FIL+1 (2), LAST = OUT_C*OUT_R-1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       frame start pulse, honoured in IDLE only
//  base_addr  in   ADDR_W  output base address, latched on accepted start
//  in_valid   in   1       result valid
//  in_ready   out  1       writer can accept
//  in_data    in   DATA_W  conv result
//  in_i       in   4       row tag of result
//  in_j       in   4       column tag of result
//  mem_we     out  1       RAM write strobe
//  mem_addr   out  ADDR_W  RAM write address
//  mem_wdata  out  DATA_W  RAM write data
//  busy       out  1       high in RUN and DONE
//  done       out  1       one-cycle pulse, frame complete
//  pos_err    out  1       sticky tag-mismatch flag
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE; row=col=0; base_q=0; all outputs 0.
//  - States: IDLE -start-> RUN -last beat accepted-> DONE -> IDLE (unconditional, 1 cycle).
//  - in_ready: 1 only in RUN, combinational from state.
//  - Accept: in_valid & in_ready. RAM is assumed always ready.
//  - Write timing: registered. The beat accepted in cycle T drives mem_we=1 in T+1, with
//    mem_addr = base_q + row*OUT_C + col and mem_wdata = data, using the row/col that were
//    current at acceptance.
//  - Idle write port: mem_we=0 in every cycle without a write. mem_addr/mem_wdata hold their
//    last values.
//  - Counters: col increments on each accept. col==OUT_C-1 wraps to 0 and increments row.
//    The accept at row==OUT_R-1 && col==OUT_C-1 moves to DONE and clears row/col.
//  - done=1 in the DONE cycle, coincident with the final mem_we.
//  - Address arithmetic is modulo 2^ADDR_W; overflow wraps silently.
//  - start during RUN/DONE is ignored. start with in_valid in the same IDLE cycle:
//    no accept until the next cycle.
//  - Tag check on every accept: in_i!=row or in_j!=col sets pos_err. The write still goes to
//    the internal-counter address. pos_err clears only on an accepted start or on reset.
//  - Reset mid-frame abandons the partial frame: no done, no further writes.
// CONFIGURATION
//  - CONV_WR_RELU_EN defined: mem_wdata = 0 when the accepted in_data is negative (MSB=1),
//    otherwise in_data.
//  - CONV_WR_RELU_EN undefined: in_data is written unchanged.
// STRUCTURE
//  - cnn_pkg: DATA_W/ADDR_W defaults, out_dim(n,fil)=n-fil+1 constant function,
//    writer state encoding (IDLE/RUN/DONE).
//  - Sub-module wr_addr_gen: row/col counters, wrap/last detect, address computation.
//  - Top level: FSM, tag check, output registers, optional ReLU.
// TESTING (defaults: OUT_C=4, OUT_R=2, 8 beats)
//  1. rst=0 with random inputs -> mem_we=0, in_ready=0, busy=0, done=0, pos_err=0.
//     Release -> IDLE.
//  2. start with base_addr=8'h10, then 8 back-to-back beats, data 1..8, correct tags ->
//     writes 8'h10..8'h17 with data 1..8; done=1 with the 8'h17 write; pos_err=0.
//  3. Same frame with in_valid toggling 1/0 -> same 8 writes, no extra mem_we,
//     done exactly once.
//  4. Beat 3 tagged (0,3) instead of (0,2) -> pos_err=1 from then on, data written to 8'h12.
//     Next start clears it.
//  5. rst=0 after 5 beats, then start with base 8'h40 -> no done for the first frame;
//     new frame writes 8'h40..8'h47.
//  6. base 8'hFC -> addresses FC,FD,FE,FF,00,01,02,03.
//     in_data=16'hFFFB -> written 0 with CONV_WR_RELU_EN, 16'hFFFB without.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the conv datapath: default widths, the output
// dimension helper and the result-writer state encoding.
package cnn_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;
   localparam int TAG_W      = 4;

   // Number of valid window positions along one axis.
   function automatic int out_dim(input int n, input int fil);
      return n - fil + 1;
   endfunction

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_RUN  = 2'd1,
      WR_DONE = 2'd2
   } wr_state_e;

endpackage

// File: rtl/conv_result_writer_wr_addr_gen.sv
// Position counters and output address generator for the result writer.
// Tracks the (row, col) window position of the next beat. Flags the last
// position of the frame. Forms base + row*OUT_C + col, which wraps modulo
// 2^ADDR_W.
module wr_addr_gen
   import cnn_pkg::*;
#(
   parameter int OUT_C  = 4,
   parameter int OUT_R  = 2,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_base,
   input  logic              i_advance,
   output logic [TAG_W-1:0]  o_row,
   output logic [TAG_W-1:0]  o_col,
   output logic              o_last,
   output logic [ADDR_W-1:0] o_addr
);

   logic [TAG_W-1:0]  r_row;
   logic [TAG_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_base;
   logic              w_colWrap;
   logic              w_rowLast;
   logic [ADDR_W-1:0] w_offset;

   assign w_colWrap = (r_col == TAG_W'(OUT_C - 1));
   assign w_rowLast = (r_row == TAG_W'(OUT_R - 1));
   assign o_last    = w_colWrap & w_rowLast;

   // Row-major position counters. They restart on a new frame and after the final beat.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row  <= '0;
         r_col  <= '0;
         r_base <= '0;
      end else if (i_load) begin
         r_base <= i_base;
         r_row  <= '0;
         r_col  <= '0;
      end else if (i_advance) begin
         if (o_last) begin
            r_row <= '0;
            r_col <= '0;
         end else if (w_colWrap) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // Truncation to ADDR_W gives the silent modulo wrap of the address.
   always_comb begin
      w_offset = ADDR_W'(int'(r_row) * OUT_C + int'(r_col));
   end

   assign o_addr = r_base + w_offset;
   assign o_row  = r_row;
   assign o_col  = r_col;

endmodule

// File: rtl/conv_result_writer.sv
// Write end of the conv sliding-window datapath. It takes one result per
// window position in row-major order and writes it to the output feature-map
// RAM through a registered write port. It pulses done with the final write.
// A sticky pos_err is raised when an incoming tag disagrees with the
// internal position.
// Optional feature: define CONV_WR_RELU_EN to clamp negative results to zero
// before writing.
module conv_result_writer
   import cnn_pkg::*;
#(
   parameter int N_C     = 5,
   parameter int N_R     = 3,
   parameter int COL_FIL = 2,
   parameter int ROW_FIL = 2,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic [TAG_W-1:0]  i_in_i,
   input  logic [TAG_W-1:0]  i_in_j,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pos_err
);

   localparam int OUT_C = out_dim(N_C, COL_FIL);
   localparam int OUT_R = out_dim(N_R, ROW_FIL);

   wr_state_e         r_state;
   wr_state_e         w_nextState;
   logic              w_accept;
   logic              w_startAcc;
   logic [TAG_W-1:0]  w_row;
   logic [TAG_W-1:0]  w_col;
   logic              w_last;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [DATA_W-1:0] r_memWdata;
   logic              r_posErr;

   assign o_in_ready = (r_state == WR_RUN);
   assign w_accept   = i_in_valid & o_in_ready;
   assign w_startAcc = i_start & (r_state == WR_IDLE);

   wr_addr_gen #(
      .OUT_C  (OUT_C),
      .OUT_R  (OUT_R),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (w_startAcc),
      .i_base    (i_base_addr),
      .i_advance (w_accept),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_last    (w_last),
      .o_addr    (w_addr)
   );

   // Writer state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= WR_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: a frame runs until its last beat is taken, then lingers one cycle in DONE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         WR_IDLE: if (i_start) w_nextState = WR_RUN;
         WR_RUN:  if (w_accept && w_last) w_nextState = WR_DONE;
         WR_DONE: w_nextState = WR_IDLE;
         default: w_nextState = WR_IDLE;
      endcase
   end

`ifdef CONV_WR_RELU_EN
   // Negative results are clamped to zero before they reach the RAM.
   always_comb begin
      w_wdata = i_in_data[DATA_W-1] ? '0 : i_in_data;
   end
`else
   // Results pass to the RAM unchanged.
   always_comb begin
      w_wdata = i_in_data;
   end
`endif

   // Registered write port. Address and data hold their last values between writes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
      end else begin
         r_memWe <= w_accept;
         if (w_accept) begin
            r_memAddr  <= w_addr;
            r_memWdata <= w_wdata;
         end
      end
   end

   // Sticky tag-mismatch flag. A new frame clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_posErr <= 1'b0;
      end else if (w_startAcc) begin
         r_posErr <= 1'b0;
      end else if (w_accept && ((i_in_i != w_row) || (i_in_j != w_col))) begin
         r_posErr <= 1'b1;
      end
   end

   assign o_mem_we    = r_memWe;
   assign o_mem_addr  = r_memAddr;
   assign o_mem_wdata = r_memWdata;
   assign o_busy      = (r_state != WR_IDLE);
   assign o_done      = (r_state == WR_DONE);
   assign o_pos_err   = r_posErr;

endmodule
